pipelined_select_adder: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor for the datapath. Successor to the fixed 16-bit carry-select adder: operand width and block size are parameters, subtraction is a per-transaction mode, and each carry-select block has its own register stage with a valid/ready handshake and backpressure. It sits between operand sources (register file / ALU muxing) and any consumer that can stall, such as a result register or a downstream FIFO.

---
 rtl/pipelined_select_adder_pkg.sv | 17 +
 rtl/pipelined_select_adder_if.sv | 27 ++
 rtl/pipelined_select_adder_select_block.sv | 39 +++
 rtl/pipelined_select_adder.sv | 160 ++++++++++++++++
 tb/tb_pipelined_select_adder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_select_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor:
// operation encoding, default block size and the geometry legality check.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEFAULT_BLOCK = 4;

  // The operand width must split into whole carry-select blocks.
  function automatic bit geometry_ok(input int width, input int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/pipelined_select_adder_if.sv
// Operand / result bus of the pipelined carry-select adder, with the
// valid/ready handshake on both sides.
interface pipelined_select_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Sum;
  logic             CO;
  logic             OV;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output A, B, Sub, in_valid, out_ready,
    input  in_ready, Sum, CO, OV, out_valid, busy
  );

  modport slave (
    input  A, B, Sub, in_valid, out_ready,
    output in_ready, Sum, CO, OV, out_valid, busy
  );
endinterface

// File: rtl/pipelined_select_adder_select_block.sv
// One combinational carry-select block: two ripple adders (carry-in 0 and 1)
// followed by a mux on the real carry-in. Also reports the carry into the
// block MSB so the top can form signed overflow.
module select_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [BLOCK:0]   c0;
  logic [BLOCK:0]   c1;
  logic [BLOCK-1:0] s0;
  logic [BLOCK-1:0] s1;

  // Both speculative ripple chains, evaluated bit by bit.
  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s     = c_in ? s1 : s0;
  assign c_out = c_in ? c1[BLOCK] : c0[BLOCK];
  assign c_msb = c_in ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder/subtractor. Stage k resolves one BLOCK-bit
// slice using the carry registered by stage k-1; unresolved operand bits
// travel down the pipe. A per-stage ready chain gives backpressure with
// bubble collapsing.
module pipelined_select_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input logic                     Clk,
  input logic                     Reset,
  pipelined_select_adder_if.slave bus
);

  localparam int NB = (BLOCK >= 1) ? (WIDTH / BLOCK) : 1;

  if (!geometry_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_select_adder: WIDTH must be a positive multiple of BLOCK");
  end

  op_e              op;
  logic [WIDTH-1:0] bx_in;
  logic [NB-1:0]    v;
  logic [NB-1:0]    adv;

  // Subtraction is A + ~B + 1: invert B here, Sub becomes stage 0 carry-in.
  assign op    = op_e'(bus.Sub);
  assign bx_in = (op == OP_SUB) ? ~bus.B : bus.B;

  // Ready chain: a stage may load if it is empty or the one after it moves.
  always_comb begin
    adv       = '0;
    adv[NB-1] = bus.out_ready | ~v[NB-1];
    for (int k = NB - 2; k >= 0; k--) begin
      adv[k] = ~v[k] | adv[k+1];
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int RW = (k + 1) * BLOCK;      // resolved sum bits after this stage
    localparam int OW = WIDTH - k * BLOCK;    // operand bits still unresolved on entry

    logic [OW-1:0]    op_a;
    logic [OW-1:0]    op_b;
    logic             src_v;
    logic             blk_ci;
    logic [BLOCK-1:0] blk_s;
    logic             blk_co;
    logic             blk_cm;
    logic [RW-1:0]    src_sum;
    logic             v_d, v_q;
    logic             c_d, c_q;
    logic [RW-1:0]    sum_d, sum_q;

    if (k == 0) begin : g_src
      assign op_a    = bus.A;
      assign op_b    = bx_in;
      assign src_v   = bus.in_valid;
      assign blk_ci  = (op == OP_SUB);
      assign src_sum = blk_s;
    end else begin : g_src
      assign op_a    = g_stage[k-1].g_fwd.a_q;
      assign op_b    = g_stage[k-1].g_fwd.b_q;
      assign src_v   = g_stage[k-1].v_q;
      assign blk_ci  = g_stage[k-1].c_q;
      assign src_sum = {blk_s, g_stage[k-1].sum_q};
    end

    select_block #(.BLOCK(BLOCK)) u_blk (
      .a     (op_a[BLOCK-1:0]),
      .b     (op_b[BLOCK-1:0]),
      .c_in  (blk_ci),
      .s     (blk_s),
      .c_out (blk_co),
      .c_msb (blk_cm)
    );

    // Load from upstream when this stage advances, otherwise hold.
    always_comb begin
      v_d   = v_q;
      c_d   = c_q;
      sum_d = sum_q;
      if (adv[k]) begin
        v_d   = src_v;
        c_d   = blk_co;
        sum_d = src_sum;
      end
    end

    // Stage register: valid, resolved sum bits and outgoing carry.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        v_q   <= v_d;
        c_q   <= c_d;
        sum_q <= sum_d;
      end
    end

    assign v[k] = v_q;

    if (k < NB - 1) begin : g_fwd
      localparam int UW = OW - BLOCK;
      logic [UW-1:0] a_d, a_q;
      logic [UW-1:0] b_d, b_q;

      // Carry the still-unresolved operand bits to the next stage.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv[k]) begin
          a_d = op_a[OW-1:BLOCK];
          b_d = op_b[OW-1:BLOCK];
        end
      end

      // Unresolved operand register.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic cm_d, cm_q;

      // Carry into the result MSB, needed only for signed overflow.
      always_comb begin
        cm_d = cm_q;
        if (adv[k]) begin
          cm_d = blk_cm;
        end
      end

      // MSB carry register.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          cm_q <= 1'b0;
        end else begin
          cm_q <= cm_d;
        end
      end
    end
  end

  assign bus.Sum       = g_stage[NB-1].sum_q;
  assign bus.CO        = g_stage[NB-1].c_q;
  assign bus.OV        = g_stage[NB-1].g_last.cm_q ^ g_stage[NB-1].c_q;
  assign bus.out_valid = v[NB-1];
  assign bus.in_ready  = adv[0];
  assign bus.busy      = |v;

endmodule

// File: tb/tb_pipelined_select_adder.sv
// Bench for pipelined_select_adder (WIDTH 16, BLOCK 4): directed literal
// cases, streaming, backpressure, mid-flight reset and a randomized run, all
// scored against an arithmetic model of add/subtract with carry and overflow.
module tb_pipelined_select_adder;

  localparam int W  = 16;
  localparam int NB = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } res_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  pipelined_select_adder_if #(.WIDTH(W)) bus ();

  pipelined_select_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: unsigned carry/borrow and signed range overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    int ua, ub, sa, sb, sres, ures;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      r.co = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      r.co = (ures > 65535);
    end
    r.sum = ures[W-1:0];
    r.ov  = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  // Scoreboard: record accepted operations, compare every output transfer,
  // and check the output is frozen while stalled.
  logic         stall_prev = 1'b0;
  logic [W+1:0] held;
  always @(negedge Clk) begin
    res_t e;
    if (Reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold", {14'd0, bus.out_valid, bus.Sum, bus.CO, bus.OV}, {14'd0, 1'b1, held});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", {16'd0, bus.Sum}, {16'd0, e.sum});
          chk("co", {31'd0, bus.CO}, {31'd0, e.co});
          chk("ov", {31'd0, bus.OV}, {31'd0, e.ov});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.A, bus.B, bus.Sub));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = {bus.Sum, bus.CO, bus.OV};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Single operation into an empty pipe; checks latency and literal results.
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    bus.out_ready = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.Sub       = sub;
    bus.in_valid  = 1'b1;
    #1;
    chk("dir_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("dir_latency", lat, NB - 1);
    chk("dir_sum", {16'd0, bus.Sum}, {16'd0, es});
    chk("dir_co", {31'd0, bus.CO}, {31'd0, eco});
    chk("dir_ov", {31'd0, bus.OV}, {31'd0, eov});
    tick();
  endtask

  task automatic drain();
    int guard = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && guard < 200) begin
      tick();
      guard++;
    end
    chk("drain_timeout", {31'd0, guard >= 200}, 32'd0);
  endtask

  initial begin
    logic [11:0] ov_seen, ov_want;
    int acc, n, cyc;
    logic took;

    bus.A = '0; bus.B = '0; bus.Sub = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_sum_co_ov", {14'd0, bus.Sum, bus.CO, bus.OV}, 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();

    // Literal cases pin both the DUT and the model.
    directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    chk("model_pin_add", {15'd0, model(16'h1234, 16'h4321, 1'b0)}, {15'd0, 16'h5555, 1'b0, 1'b0});
    chk("model_pin_sub", {15'd0, model(16'h8000, 16'h0001, 1'b1)}, {15'd0, 16'h7FFF, 1'b1, 1'b1});

    // Streaming: 8 back-to-back ops give 8 consecutive results.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = (i < 8);
      bus.A        = 16'($urandom);
      bus.B        = 16'($urandom);
      bus.Sub      = 1'($urandom);
      tick();
      ov_seen[i] = bus.out_valid;
      ov_want[i] = (i >= NB - 1) && (i < NB - 1 + 8);
    end
    chk("stream_pattern", {20'd0, ov_seen}, {20'd0, ov_want});
    drain();

    // Backpressure: out_ready low for 10 cycles, capacity is NB.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Sub = 1'($urandom);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      took = bus.in_ready;
      if (took) acc++;
      tick();
      if (took) begin
        bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Sub = 1'($urandom);
      end
    end
    chk("bp_accepted", acc, NB);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_busy", {31'd0, bus.busy}, 32'd1);
    drain();

    // Randomized traffic with toggling backpressure.
    n = 0; cyc = 0; took = 1'b0;
    bus.in_valid = 1'b0;
    while (n < 500 && cyc < 20000) begin
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Sub = 1'($urandom);
        if ($urandom_range(0, 7) == 0) bus.B = bus.A;
      end
      bus.out_ready = 1'($urandom);
      #1;
      took = bus.in_valid && bus.in_ready;
      if (took) n++;
      tick();
      cyc++;
    end
    chk("rand_timeout", {31'd0, cyc >= 20000}, 32'd0);
    drain();

    // Mid-flight reset discards three in-flight operations.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Sub = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
    end
    directed(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
